widen_arbiter: RTL
==================

WIDEN_ARBITER -- requirements
Module: widen_arbiter

Interface
REQ-001 Parameter LANES, default 8, SHALL set the number of sample lanes per row.
REQ-002 Parameter IN_W, default 8, SHALL set the input sample width in bits.
REQ-003 Parameter OUT_W, default 16, SHALL set the widened sample width in bits, with OUT_W >= IN_W.
REQ-004 Parameter ROWS, default 8, SHALL set the rows per block, with ROWS >= 2.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-007 req0_valid / req1_valid  in  1  SHALL flag a row offered by requester 0 / 1.
REQ-008 req0_data / req1_data  in  LANES*IN_W  SHALL carry the row; lane k occupies bits [k*IN_W +: IN_W].
REQ-009 req0_ready / req1_ready  out  1  SHALL flag row acceptance by the arbiter.
REQ-010 out_valid  out  1  SHALL flag a widened row held on the output.
REQ-011 out_data  out  LANES*OUT_W  SHALL carry the widened row; lane k occupies bits [k*OUT_W +: OUT_W].
REQ-012 out_src  out  1  SHALL identify the requester that supplied the row.
REQ-013 out_row  out  clog2(ROWS)  SHALL give the row index within the block.
REQ-014 out_last  out  1  SHALL flag the final row of a block.
REQ-015 out_ready  in  1  SHALL flag downstream acceptance of the output row.
REQ-016 busy  out  1  SHALL be high while a block is owned.

Function
REQ-017 The FSM SHALL have three states: IDLE, OWN0, OWN1.
REQ-018 In IDLE with exactly one reqN_valid high, the FSM SHALL move to OWNN on the next edge.
REQ-019 In IDLE with both valids high, the FSM SHALL grant the requester not served last (round-robin); after reset, requester 0 wins.
REQ-020 In IDLE, both readys SHALL be 0.
REQ-021 The non-owner ready SHALL be 0 at all times.
REQ-022 The owner ready SHALL equal (!out_valid || out_ready).
REQ-023 A row transfer SHALL occur when the owner valid and ready are both high.
REQ-024 On a transfer, the output register SHALL load on the same edge, giving 1-cycle latency:
  - each lane zero-extended to OUT_W;
  - out_src = owner;
  - out_row = row_cnt;
  - out_last = (row_cnt == ROWS-1);
  - out_valid = 1.
REQ-025 row_cnt SHALL increment on each transfer and wrap to 0 after ROWS-1.
REQ-026 On the final-row transfer, the FSM SHALL return to IDLE and record the owner as last served.
REQ-027 Blocks SHALL be atomic: no row from the other requester is accepted until the owner's block completes.
REQ-028 If the owner drops valid mid-block, the FSM SHALL stay in OWNN indefinitely and keep row_cnt.
REQ-029 Without a transfer, an output with out_valid=1 SHALL hold all output fields stable until out_ready=1.
REQ-030 With out_ready=1 and no new transfer, out_valid SHALL clear on the next edge.
REQ-031 A transfer in the same cycle as out_ready=1 SHALL replace the output with no bubble, giving 1 row/cycle sustained.
REQ-032 One IDLE cycle SHALL separate consecutive blocks.
REQ-033 busy SHALL be 1 exactly in OWN0 and OWN1.

Reset
REQ-034 Asserting rst SHALL immediately force the following, independent of clk:
  - state IDLE, row_cnt 0, last-served = requester 1;
  - out_valid, out_last, out_src, out_row, busy = 0;
  - out_data = 0.
REQ-035 Reset mid-block SHALL discard the partial block; no row SHALL be emitted for it after release.

Structure
REQ-036 The shared package SHALL hold the state enum (IDLE/OWN0/OWN1) and the LANES/IN_W/OUT_W/ROWS defaults.
REQ-037 The per-lane zero extension SHALL be a combinational sub-module, widen_lanes (LANES*IN_W in, LANES*OUT_W out).

Verification
REQ-038 Single requester: req0 sends 8 rows, lane0 = 0x00..0x07, out_ready=1 → 8 consecutive outputs:
  - lane0 = 0x0000..0x0007, out_row 0..7;
  - out_last only on row 7;
  - out_src=0;
  - busy deasserts in the following cycle.
REQ-039 Contention: both valid continuously from reset → blocks granted in order 0, 1, 0, 1; never two rows from different sources within one block.
REQ-040 Backpressure: out_ready=0 for 3 cycles at row 2 → out_data/out_row hold at row 2, owner ready=0; resumes with row 3, no loss or duplicate.
REQ-041 Zero extension: lane value 0xFF → 0x00FF; all lanes 0x80 → every output lane 0x0080.
REQ-042 Owner stall: req1 drops valid after row 4 for 5 cycles while req0 is valid → req0_ready stays 0; req1 rows 5..7 complete afterwards.
REQ-043 Reset after row 3 of a block → out_valid=0 immediately; next block starts at out_row 0 and requester 0 wins the first contention.

Source files
------------

// File: rtl/widen_arbiter_pkg.sv
// widen_arbiter_pkg: shared FSM state type and default geometry for the widening arbiter
package widen_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam int LANES_DEF = 8;
    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 16;
    localparam int ROWS_DEF  = 8;
endpackage

// File: rtl/widen_arbiter_lanes.sv
// widen_lanes: combinational per-lane zero extension from IN_W to OUT_W bits
module widen_lanes
    import widen_arbiter_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [LANES*IN_W-1:0]  din,
    output logic [LANES*OUT_W-1:0] dout
);
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign dout[k*OUT_W +: OUT_W] = OUT_W'(din[k*IN_W +: IN_W]);
    end
endmodule

// File: rtl/widen_arbiter.sv
// widen_arbiter: two-requester round-robin block arbiter emitting zero-extended rows
module widen_arbiter
    import widen_arbiter_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int ROWS  = ROWS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [LANES*IN_W-1:0]    req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [LANES*IN_W-1:0]    req1_data,
    output logic                     req1_ready,
    output logic                     out_valid,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic                     out_src,
    output logic [$clog2(ROWS)-1:0]  out_row,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy
);
    localparam int RW = $clog2(ROWS);

    state_t                 state, state_nx;
    logic [RW-1:0]          row_cnt;
    logic                   last_srv, owner, own_valid, can_load, xfer, last_row;
    logic [LANES*OUT_W-1:0] wide;

    widen_lanes #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) u_widen (
        .din  (owner ? req1_data : req0_data),
        .dout (wide)
    );

    assign busy = state != IDLE;

    // Handshake and next state; only the block owner ever sees ready, so blocks stay atomic.
    always_comb begin
        owner      = state == OWN1;
        own_valid  = state == OWN0 ? req0_valid : state == OWN1 ? req1_valid : 1'b0;
        can_load   = !out_valid || out_ready;
        req0_ready = state == OWN0 && can_load;
        req1_ready = state == OWN1 && can_load;
        xfer       = own_valid && can_load;
        last_row   = row_cnt == RW'(ROWS - 1);
        state_nx   = state;
        if (state == IDLE)
            state_nx = req0_valid && req1_valid ? (last_srv ? OWN0 : OWN1) :
                       req0_valid ? OWN0 : req1_valid ? OWN1 : IDLE;
        else if (xfer && last_row)
            state_nx = IDLE;
    end

    // State, round-robin memory and row position within the current block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row_cnt  <= '0;
            last_srv <= 1'b1;
        end else begin
            state <= state_nx;
            if (xfer) row_cnt <= last_row ? '0 : row_cnt + RW'(1);
            if (xfer && last_row) last_srv <= owner;
        end
    end

    // Output row register: a transfer overwrites it, otherwise it drains once accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= wide;
            out_src   <= owner;
            out_row   <= row_cnt;
            out_last  <= last_row;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
